// File: rtl/gpio_cfg_pkg.sv
// Shared types and constants for the GPIO pad-strip serial configuration loader.
package gpio_cfg_pkg;

  localparam int PAD_CTRL_BITS_DEF = 12;
  localparam logic [PAD_CTRL_BITS_DEF-1:0] PAD_DEFAULT_DEF = 12'hC00;

  typedef logic [PAD_CTRL_BITS_DEF-1:0] pad_cfg_t;

  typedef enum logic [1:0] {
    CFG_IDLE  = 2'd0,
    CFG_SHIFT = 2'd1,
    CFG_LOAD  = 2'd2
  } cfg_state_t;

endpackage

// File: rtl/gpio_cfg_shifter.sv
// Streams a flat snapshot MSB-first into the pad chain, then issues one load slot.
module gpio_cfg_shifter
  import gpio_cfg_pkg::*;
#(
  parameter int N_BITS  = 168,
  parameter int CLK_DIV = 2
) (
  input  logic              mclk,
  input  logic              reset,
  input  logic              start,
  input  logic [N_BITS-1:0] snap,
  output logic              busy,
  output logic              done,
  output logic              serial_clock,
  output logic              serial_data,
  output logic              serial_load
);

  localparam int PH_W = $clog2(2 * CLK_DIV);
  localparam int BC_W = (N_BITS > 1) ? $clog2(N_BITS) : 1;
  localparam logic [PH_W-1:0] PH_LAST  = PH_W'(2 * CLK_DIV - 1);
  localparam logic [PH_W-1:0] PH_RISE  = PH_W'(CLK_DIV);
  localparam logic [BC_W-1:0] BIT_LAST = BC_W'(N_BITS - 1);

  cfg_state_t        state_r, state_s;
  logic [PH_W-1:0]   ph_r, ph_s, ph_inc_s;
  logic [BC_W-1:0]   bit_r, bit_s;
  logic [N_BITS-1:0] sreg_r, sreg_s;
  logic              busy_s, done_s, sclk_s, sdata_s, sload_s;

  // state and registered serial outputs
  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      state_r      <= CFG_IDLE;
      ph_r         <= '0;
      bit_r        <= '0;
      sreg_r       <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      serial_clock <= 1'b0;
      serial_data  <= 1'b0;
      serial_load  <= 1'b0;
    end else begin
      state_r      <= state_s;
      ph_r         <= ph_s;
      bit_r        <= bit_s;
      sreg_r       <= sreg_s;
      busy         <= busy_s;
      done         <= done_s;
      serial_clock <= sclk_s;
      serial_data  <= sdata_s;
      serial_load  <= sload_s;
    end
  end

  // next-state and next-output logic; data only moves on a phase wrap, when the clock is low
  always_comb begin
    state_s  = state_r;
    ph_s     = ph_r;
    bit_s    = bit_r;
    sreg_s   = sreg_r;
    busy_s   = busy;
    done_s   = 1'b0;
    sclk_s   = serial_clock;
    sdata_s  = serial_data;
    sload_s  = serial_load;
    ph_inc_s = ph_r + PH_W'(1);
    case (state_r)
      CFG_IDLE: begin
        if (start) begin
          state_s = CFG_SHIFT;
          ph_s    = '0;
          bit_s   = '0;
          sreg_s  = snap;
          busy_s  = 1'b1;
          sclk_s  = 1'b0;
          sdata_s = snap[N_BITS-1];
          sload_s = 1'b0;
        end else begin
          busy_s  = 1'b0;
          sclk_s  = 1'b0;
          sdata_s = 1'b0;
          sload_s = 1'b0;
        end
      end
      CFG_SHIFT: begin
        if (ph_r == PH_LAST) begin
          ph_s   = '0;
          sclk_s = 1'b0;
          if (bit_r == BIT_LAST) begin
            state_s = CFG_LOAD;
            sdata_s = 1'b0;
            sload_s = 1'b1;
          end else begin
            bit_s   = bit_r + BC_W'(1);
            sreg_s  = {sreg_r[N_BITS-2:0], 1'b0};
            sdata_s = sreg_r[N_BITS-2];
          end
        end else begin
          ph_s   = ph_inc_s;
          sclk_s = (ph_inc_s >= PH_RISE);
        end
      end
      CFG_LOAD: begin
        if (ph_r == PH_LAST) begin
          state_s = CFG_IDLE;
          ph_s    = '0;
          busy_s  = 1'b0;
          done_s  = 1'b1;
          sload_s = 1'b0;
        end else begin
          ph_s = ph_inc_s;
        end
      end
      default: begin
        state_s = CFG_IDLE;
        ph_s    = '0;
        busy_s  = 1'b0;
        sclk_s  = 1'b0;
        sdata_s = 1'b0;
        sload_s = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/gpio_cfg_loader.sv
// Per-pad configuration register file with readback, feeding the serial chain shifter.
module gpio_cfg_loader
  import gpio_cfg_pkg::*;
#(
  parameter int                     N_PADS        = 14,
  parameter int                     PAD_CTRL_BITS = PAD_CTRL_BITS_DEF,
  parameter logic [PAD_CTRL_BITS-1:0] PAD_DEFAULT = PAD_DEFAULT_DEF,
  parameter int                     CLK_DIV       = 2,
  parameter int                     AUTO_LOAD     = 1
) (
  input  logic                       mclk,
  input  logic                       reset,
  input  logic                       cfg_we,
  input  logic [$clog2(N_PADS)-1:0]  cfg_addr,
  input  logic [PAD_CTRL_BITS-1:0]   cfg_wdata,
  output logic [PAD_CTRL_BITS-1:0]   cfg_rdata,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  output logic                       serial_clock,
  output logic                       serial_data,
  output logic                       serial_load
);

  localparam int AW     = $clog2(N_PADS);
  localparam int N_BITS = N_PADS * PAD_CTRL_BITS;

  logic [PAD_CTRL_BITS-1:0] cfg_r [N_PADS];
  logic [N_BITS-1:0]        snap_s;
  logic                     in_range_s;
  logic                     auto_pend_r;
  logic                     go_s;

  assign in_range_s = ({1'b0, cfg_addr} < (AW + 1)'(N_PADS));
  assign go_s       = start | auto_pend_r;

  // config word storage; out-of-range writes are dropped
  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < N_PADS; k++) cfg_r[k] <= PAD_DEFAULT;
    end else if (cfg_we && in_range_s) begin
      cfg_r[cfg_addr] <= cfg_wdata;
    end
  end

  // readback mux
  always_comb begin
    if (in_range_s) begin
      cfg_rdata = cfg_r[cfg_addr];
    end else begin
      cfg_rdata = '0;
    end
  end

  // one-shot auto-load request armed by reset, consumed by the first idle cycle
  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      auto_pend_r <= (AUTO_LOAD != 0);
    end else if (auto_pend_r && !busy) begin
      auto_pend_r <= 1'b0;
    end
  end

  // pad N_PADS-1 occupies the top of the snapshot so it leaves the chain output first
  for (genvar k = 0; k < N_PADS; k++) begin : g_snap
    assign snap_s[k*PAD_CTRL_BITS +: PAD_CTRL_BITS] = cfg_r[k];
  end

  gpio_cfg_shifter #(
    .N_BITS  (N_BITS),
    .CLK_DIV (CLK_DIV)
  ) u_shifter (
    .mclk         (mclk),
    .reset        (reset),
    .start        (go_s),
    .snap         (snap_s),
    .busy         (busy),
    .done         (done),
    .serial_clock (serial_clock),
    .serial_data  (serial_data),
    .serial_load  (serial_load)
  );

endmodule
